// File: rtl/pw_vault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pw_vault_ctrl
// Brief    : Per-user password vault with digit entry, in-session password
//            change and optional failed-attempt lockout (PW_LOCKOUT_EN).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pw_vault_ctrl #(
    parameter int                               NUM_USERS   = 8,
    parameter int                               DIGIT_W     = 4,
    parameter int                               PW_DIGITS   = 4,
    parameter logic [DIGIT_W*PW_DIGITS-1:0]     INIT_PW     = 16'h1234,
    parameter int                               MAX_TRIES   = 3,
    parameter int                               LOCK_CYCLES = 1024,
    localparam int                              UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    localparam int                              CNT_W = $clog2(PW_DIGITS + 1),
    localparam int                              PW_W  = DIGIT_W * PW_DIGITS
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [UID_W-1:0]    user_id,
    input  logic [DIGIT_W-1:0]  digit_in,
    input  logic                digit_valid,
    input  logic                enter,
    input  logic                change_req,
    input  logic                log_out,
    output logic                auth_bit,
    output logic                green_led,
    output logic                red_led,
    output logic [2:0]          status,
    output logic [CNT_W-1:0]    digit_count,
    output logic [3:0]          fail_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANTED = 3'd3,
        S_CHANGE  = 3'd4,
        S_LOCKED  = 3'd5
    } state_t;

    localparam logic [2:0]       c_ST_IDLE    = 3'd0;
    localparam logic [2:0]       c_ST_ENTRY   = 3'd1;
    localparam logic [2:0]       c_ST_GRANTED = 3'd2;
    localparam logic [2:0]       c_ST_DENIED  = 3'd3;
    localparam logic [2:0]       c_ST_CHANGE  = 3'd4;
    localparam logic [2:0]       c_ST_CHANGED = 3'd5;
    localparam logic [CNT_W-1:0] c_FULL       = CNT_W'(PW_DIGITS);

`ifdef PW_LOCKOUT_EN
    localparam int               TMR_W        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TMR_W-1:0] c_LOCK_LOAD  = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       c_MAX_TRIES  = 4'(MAX_TRIES);
    localparam logic [2:0]       c_ST_LOCKED  = 3'd6;
`endif

    if (MAX_TRIES < 1 || MAX_TRIES > 15 || LOCK_CYCLES < 1 || NUM_USERS < 1 || PW_DIGITS < 1) begin : g_bad_param
        $error("pw_vault_ctrl: parameter out of range");
    end

    state_t             r_state, w_state;
    logic [PW_W-1:0]    r_buf, w_buf;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [UID_W-1:0]   r_uid_q, w_uid_q;
    logic [PW_W-1:0]    r_slot [NUM_USERS];
    logic               r_auth, w_auth;
    logic               r_red, w_red;
    logic [2:0]         r_status, w_status;
    logic [3:0]         r_fail, w_fail;
    logic               w_wr_en;
`ifdef PW_LOCKOUT_EN
    logic [TMR_W-1:0]   r_timer, w_timer;
`endif

    logic [PW_W-1:0]    w_buf_sh;
    logic [PW_W-1:0]    w_slot_sel;
    logic               w_uid_ok;
    logic               w_full;
    logic               w_shift;
    logic               w_match;
    logic [3:0]         w_fail_inc;

    if (PW_DIGITS > 1) begin : g_shift_multi
        assign w_buf_sh = {r_buf[PW_W-DIGIT_W-1:0], digit_in};
    end else begin : g_shift_single
        assign w_buf_sh = digit_in;
    end

    // Explicit decode so an out-of-range uid_q can never alias onto a slot
    always_comb begin
        w_uid_ok   = 1'b0;
        w_slot_sel = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (r_uid_q == UID_W'(i)) begin
                w_uid_ok   = 1'b1;
                w_slot_sel = r_slot[i];
            end
        end
    end

    assign w_full     = (r_cnt == c_FULL);
    assign w_shift    = digit_valid && !enter && !w_full;
    assign w_match    = w_uid_ok && (w_slot_sel == r_buf);
    assign w_fail_inc = (r_fail == 4'hF) ? r_fail : r_fail + 4'd1;

    always_comb begin
        w_state  = r_state;
        w_buf    = r_buf;
        w_cnt    = r_cnt;
        w_uid_q  = r_uid_q;
        w_auth   = r_auth;
        w_red    = r_red;
        w_status = r_status;
        w_fail   = r_fail;
        w_wr_en  = 1'b0;
`ifdef PW_LOCKOUT_EN
        w_timer  = r_timer;
`endif
        case (r_state)
            S_IDLE: begin
                if (digit_valid && !enter) begin
                    w_state  = S_ENTRY;
                    w_red    = 1'b0;
                    w_status = c_ST_ENTRY;
                    w_buf    = w_buf_sh;
                    w_cnt    = r_cnt + CNT_W'(1);
                end
            end
            S_ENTRY: begin
                if (enter) begin
                    if (w_full) begin
                        w_state = S_CHECK;
                        w_uid_q = user_id;
                    end
                end else if (w_shift) begin
                    w_buf = w_buf_sh;
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_CHECK: begin
                w_buf = '0;
                w_cnt = '0;
                if (w_match) begin
                    w_state  = S_GRANTED;
                    w_auth   = 1'b1;
                    w_status = c_ST_GRANTED;
                    w_fail   = 4'd0;
                end else begin
                    w_state  = S_IDLE;
                    w_red    = 1'b1;
                    w_status = c_ST_DENIED;
                    w_fail   = w_fail_inc;
`ifdef PW_LOCKOUT_EN
                    if (w_fail_inc >= c_MAX_TRIES) begin
                        w_state  = S_LOCKED;
                        w_status = c_ST_LOCKED;
                        w_timer  = c_LOCK_LOAD;
                    end
`endif
                end
            end
            S_GRANTED: begin
                if (log_out) begin
                    w_state  = S_IDLE;
                    w_auth   = 1'b0;
                    w_status = c_ST_IDLE;
                    w_buf    = '0;
                    w_cnt    = '0;
                end else if (change_req) begin
                    w_state  = S_CHANGE;
                    w_status = c_ST_CHANGE;
                    w_buf    = '0;
                    w_cnt    = '0;
                end else if (digit_valid || enter) begin
                    // Any strobe retires the "changed" indication
                    w_status = c_ST_GRANTED;
                end
            end
            S_CHANGE: begin
                if (log_out) begin
                    w_state  = S_IDLE;
                    w_auth   = 1'b0;
                    w_status = c_ST_IDLE;
                    w_buf    = '0;
                    w_cnt    = '0;
                end else if (enter) begin
                    if (w_full) begin
                        w_wr_en  = w_uid_ok;
                        w_state  = S_GRANTED;
                        w_status = c_ST_CHANGED;
                        w_buf    = '0;
                        w_cnt    = '0;
                    end
                end else if (w_shift) begin
                    w_buf = w_buf_sh;
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
`ifdef PW_LOCKOUT_EN
            S_LOCKED: begin
                if (r_timer == '0) begin
                    w_state  = S_IDLE;
                    w_status = c_ST_IDLE;
                    w_red    = 1'b0;
                    w_fail   = 4'd0;
                end else begin
                    w_timer = r_timer - TMR_W'(1);
                end
            end
`endif
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_uid_q  <= '0;
            r_auth   <= 1'b0;
            r_red    <= 1'b0;
            r_status <= c_ST_IDLE;
            r_fail   <= 4'd0;
`ifdef PW_LOCKOUT_EN
            r_timer  <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_buf    <= w_buf;
            r_cnt    <= w_cnt;
            r_uid_q  <= w_uid_q;
            r_auth   <= w_auth;
            r_red    <= w_red;
            r_status <= w_status;
            r_fail   <= w_fail;
`ifdef PW_LOCKOUT_EN
            r_timer  <= w_timer;
`endif
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                r_slot[i] <= INIT_PW;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (r_uid_q == UID_W'(i)) begin
                    r_slot[i] <= r_buf;
                end
            end
        end
    end

    assign auth_bit    = r_auth;
    assign green_led   = r_auth;
    assign red_led     = r_red;
    assign status      = r_status;
    assign digit_count = r_cnt;
    assign fail_count  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_pw_vault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_vault_ctrl
// Brief    : Directed bench for pw_vault_ctrl with a session-level reference
//            model checked every cycle plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_vault_ctrl;

    localparam int NUM_USERS   = 8;
    localparam int PW_DIGITS   = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [2:0] uid   = '0;
    logic [3:0] d     = '0;
    logic       dv    = 1'b0;
    logic       en    = 1'b0;
    logic       cr    = 1'b0;
    logic       lo    = 1'b0;
    logic       auth_bit, green_led, red_led;
    logic [2:0] status;
    logic [2:0] digit_count;
    logic [3:0] fail_count;

    int checks = 0;
    int errors = 0;

    pw_vault_ctrl #(
        .NUM_USERS   (NUM_USERS),
        .DIGIT_W     (4),
        .PW_DIGITS   (PW_DIGITS),
        .INIT_PW     (16'h1234),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .user_id     (uid),
        .digit_in    (d),
        .digit_valid (dv),
        .enter       (en),
        .change_req  (cr),
        .log_out     (lo),
        .auth_bit    (auth_bit),
        .green_led   (green_led),
        .red_led     (red_led),
        .status      (status),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Session-level reference: passwords as numbers, entry as a digit queue
    logic [15:0] m_pw [NUM_USERS];
    int          m_q [$];
    bit          m_auth = 0, m_chg = 0, m_chk = 0, m_red = 0;
    int          m_uid = 0, m_fail = 0, m_lock = 0, m_status = 0;

    function automatic logic [15:0] pack_q();
        int v = 0;
        foreach (m_q[k]) v = v * 16 + m_q[k];
        return v[15:0];
    endfunction

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            foreach (m_pw[k]) m_pw[k] = 16'h1234;
            m_q.delete();
            m_auth = 0; m_chg = 0; m_chk = 0; m_red = 0;
            m_uid = 0; m_fail = 0; m_lock = 0; m_status = 0;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_status = 0; m_red = 0; m_fail = 0;
            end
        end else if (m_chk) begin
            m_chk = 0;
            if (m_uid < NUM_USERS && m_pw[m_uid] == pack_q()) begin
                m_auth = 1; m_status = 2; m_fail = 0;
            end else begin
                if (m_fail < 15) m_fail++;
                m_red = 1; m_status = 3;
`ifdef PW_LOCKOUT_EN
                if (m_fail >= MAX_TRIES) begin
                    m_status = 6; m_lock = LOCK_CYCLES;
                end
`endif
            end
            m_q.delete();
        end else if (m_auth) begin
            if (lo) begin
                m_auth = 0; m_chg = 0; m_q.delete(); m_status = 0;
            end else if (!m_chg) begin
                if (cr) begin
                    m_chg = 1; m_q.delete(); m_status = 4;
                end else if (dv || en) begin
                    m_status = 2;
                end
            end else if (en) begin
                if (m_q.size() == PW_DIGITS) begin
                    m_pw[m_uid] = pack_q(); m_q.delete(); m_chg = 0; m_status = 5;
                end
            end else if (dv && m_q.size() < PW_DIGITS) begin
                m_q.push_back(int'(d));
            end
        end else if (en) begin
            if (m_q.size() == PW_DIGITS) begin
                m_chk = 1; m_uid = int'(uid);
            end
        end else if (dv) begin
            if (m_q.size() < PW_DIGITS) m_q.push_back(int'(d));
            m_status = 1; m_red = 0;
        end
    end

    always @(negedge clock) begin
        chk("auth_bit",    auth_bit,    m_auth);
        chk("green_led",   green_led,   m_auth);
        chk("red_led",     red_led,     m_red);
        chk("status",      status,      m_status);
        chk("digit_count", digit_count, m_q.size());
        chk("fail_count",  fail_count,  m_fail);
    end

    task automatic step(input logic v, input logic [3:0] dd, input logic e,
                        input logic c, input logic l, input logic [2:0] u);
        dv = v; d = dd; en = e; cr = c; lo = l; uid = u;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic digits(input logic [15:0] v);
        for (int k = 3; k >= 0; k--) step(1'b1, v[k*4 +: 4], 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic submit(input logic [2:0] u);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, u);
        idle(1);
    endtask

    task automatic logout();
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0);
    endtask

    initial begin
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("reset status", status, 3'd0);
        chk("reset auth", auth_bit, 1'b0);
        chk("reset red", red_led, 1'b0);
        chk("reset fail", fail_count, 4'd0);
        chk("reset count", digit_count, 3'd0);

        // Default password on user 5, grant visible on second edge
        digits(16'h1234);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd5);
        chk("auth after 1 edge", auth_bit, 1'b0);
        idle(1);
        chk("login auth", auth_bit, 1'b1);
        chk("login green", green_led, 1'b1);
        chk("login status", status, 3'd2);
        chk("login fail", fail_count, 4'd0);
        logout();
        chk("logout status", status, 3'd0);

        // Wrong password, then the next digit clears the denial
        digits(16'h1235);
        submit(3'd5);
        chk("deny red", red_led, 1'b1);
        chk("deny status", status, 3'd3);
        chk("deny fail", fail_count, 4'd1);
        chk("deny auth", auth_bit, 1'b0);
        step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("digit clears red", red_led, 1'b0);
        chk("digit status", status, 3'd1);
        step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd0);
        submit(3'd5);
        chk("regrant fail", fail_count, 4'd0);
        logout();

        // Password change on user 2
        digits(16'h1234);
        submit(3'd2);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("change status", status, 3'd4);
        digits(16'hABCD);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("changed status", status, 3'd5);
        logout();
        chk("post-change logout", status, 3'd0);
        digits(16'h1234);
        submit(3'd2);
        chk("old pw user2", status, 3'd3);
        digits(16'hABCD);
        submit(3'd2);
        chk("new pw user2", status, 3'd2);
        logout();
        digits(16'h1234);
        submit(3'd3);
        chk("user3 untouched", status, 3'd2);
        logout();

        // Short enter, enter+digit collision, overflow digit
        step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(1);
        chk("short enter status", status, 3'd1);
        chk("short enter count", digit_count, 3'd3);
        step(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("enter drops digit", digit_count, 3'd3);
        step(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("5th digit count", digit_count, 3'd4);
        submit(3'd0);
        chk("buffer kept 1234", status, 3'd2);
        logout();

        // Abandoned change: log_out wins over enter
        digits(16'h1234);
        submit(3'd3);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("change 2 digits", digit_count, 3'd2);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0);
        chk("abort status", status, 3'd0);
        chk("abort auth", auth_bit, 1'b0);
        chk("abort count", digit_count, 3'd0);
        digits(16'h1234);
        submit(3'd3);
        chk("abort slot kept", status, 3'd2);
        logout();

        // Three consecutive failures
        for (int t = 0; t < 3; t++) begin
            digits(16'h9999);
            submit(3'd0);
        end
`ifdef PW_LOCKOUT_EN
        chk("lock status", status, 3'd6);
        chk("lock red", red_led, 1'b1);
        digits(16'h1234);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("lock ignores entry", status, 3'd6);
        chk("lock auth", auth_bit, 1'b0);
        begin
            int w = 0;
            while (status !== 3'd0 && w < 40) begin
                idle(1);
                w++;
            end
        end
        chk("lock release", status, 3'd0);
        chk("lock fail cleared", fail_count, 4'd0);
        chk("lock red cleared", red_led, 1'b0);
`else
        chk("no lock status", status, 3'd3);
        chk("no lock fail", fail_count, 4'd3);
        chk("no lock red", red_led, 1'b1);
`endif
        digits(16'h1234);
        submit(3'd0);
        chk("post-fail grant", status, 3'd2);
        chk("post-fail count", fail_count, 4'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pw_vault_ctrl.md
Name: pw_vault_ctrl

Overview:
- Parametrised successor to the fixed 3-bit-id / 16-bit-password RAM access block.
- Stores one password per user in an internal register array. Collects digits through an entry shift buffer and authenticates against the selected user's password.
- Supports in-session password change and a failed-attempt lockout.
- Sits between the toggle/button debouncers and the LED/status display logic of the memory-tester top level.

Parameters:
- NUM_USERS, 8: number of user slots; UID_W = clog2(NUM_USERS), minimum 1.
- DIGIT_W, 4: bits per entered digit.
- PW_DIGITS, 4: digits per password; PW_W = DIGIT_W*PW_DIGITS.
- INIT_PW, 16'h1234: reset value loaded into every slot, PW_W bits.
- MAX_TRIES, 3: consecutive failures before lockout, 1..15.
- LOCK_CYCLES, 1024: lockout duration in clock cycles, at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- user_id  in  UID_W  slot selector; sampled only on a qualifying enter.
- digit_in  in  DIGIT_W  digit value.
- digit_valid  in  1  one-cycle strobe; shifts digit_in into the buffer.
- enter  in  1  one-cycle submit strobe.
- change_req  in  1  one-cycle request to change the current user's password.
- log_out  in  1  one-cycle strobe; ends the session.
- auth_bit  out  1  high while authenticated (GRANTED or CHANGE).
- green_led  out  1  equals auth_bit.
- red_led  out  1  denial/lock indicator.
- status  out  3  0 IDLE, 1 ENTRY, 2 GRANTED, 3 DENIED, 4 CHANGE, 5 CHANGED, 6 LOCKED.
- digit_count  out  clog2(PW_DIGITS+1)  number of digits currently buffered.
- fail_count  out  4  consecutive failed attempts.

Behaviour:
- Reset (rst low, async):
  - State IDLE; all slots = INIT_PW; buffer and digit_count = 0.
  - auth_bit = 0, red_led = 0, status = 0, fail_count = 0, lock timer = 0.
- All outputs are registered.
- Buffer:
  - On digit_valid: buffer = {buffer[PW_W-DIGIT_W-1:0], digit_in} and digit_count++.
  - digit_valid with digit_count == PW_DIGITS is ignored.
  - enter and digit_valid in the same cycle: enter wins and the digit is discarded.
- IDLE: digit_valid moves to ENTRY and clears red_led.
- ENTRY:
  - enter with digit_count < PW_DIGITS is ignored; state and status unchanged.
  - enter with a full buffer latches user_id into uid_q and moves to CHECK.
- CHECK (1 cycle): compares buffer with slot[uid_q]. In both cases the buffer is cleared.
  - Match: go to GRANTED, fail_count = 0.
  - Mismatch: fail_count++, red_led = 1, status = 3, go to IDLE. Status 3 holds until the next digit_valid.
  - auth_bit/status update on the 2nd rising edge after enter is sampled.
- GRANTED:
  - change_req moves to CHANGE and clears the buffer.
  - Later changes on user_id are ignored for the session.
- CHANGE:
  - Digits are collected as in ENTRY.
  - enter with a full buffer writes slot[uid_q] = buffer, clears the buffer, returns to GRANTED, and shows status 5 until the next strobe.
  - enter with a short buffer is ignored.
- log_out in GRANTED or CHANGE: go to IDLE, clear auth_bit and the buffer, and discard any in-progress change. log_out has priority over change_req and enter in the same cycle. log_out in other states is ignored.
- Only CHANGE writes storage; slots never alias. uid_q >= NUM_USERS is treated as a mismatch, with no write.

Optional Feature:
- Macro: PW_LOCKOUT_EN.
- Defined:
  - When fail_count reaches MAX_TRIES in CHECK, go to LOCKED: red_led = 1, status = 6, timer loaded with LOCK_CYCLES-1.
  - In LOCKED, digit_valid, enter, change_req and log_out are all ignored. Timer decrements each cycle.
  - When the timer reaches 0: go to IDLE, fail_count = 0, red_led = 0.
  - Reset mid-lock clears the lock.
- Undefined: no LOCKED state; fail_count saturates at 15; retries are unlimited.

Test Plan:
- Reset, then digits 1,2,3,4, enter with user_id=5 -> auth_bit=1, green_led=1, status=2 two edges after enter; fail_count=0.
- Digits 1,2,3,5, enter -> red_led=1, status=3, fail_count=1, auth_bit=0; the next digit_valid clears red_led.
- Log in as user 2, change_req, digits A,B,C,D, enter -> status=5. Then log_out, status=0. Afterwards: 1234 on user 2 is denied, ABCD on user 2 is granted, and 1234 on user 3 is still granted.
- Only 3 digits then enter -> no state change, status=1. A 5th digit_valid leaves digit_count=4 and the buffer unchanged. enter together with digit_valid -> digit is dropped.
- In CHANGE with 2 digits, log_out together with enter -> IDLE, auth_bit=0, slot unchanged.
- With PW_LOCKOUT_EN, MAX_TRIES=3, LOCK_CYCLES=16: 3 wrong entries -> status=6, red_led=1. A correct entry during lock is ignored. After 16 cycles -> status=0, fail_count=0, and a correct entry is granted.
